data_bus_arbiter: RTL and testbench

- Shares the single data-bus master port of the system bridge between two requesters.
  - M0: CPU MEM-stage load/store port.
  - M1: a secondary master (DMA/debug loader).
- Sits between the masters and the bridge's temp_m_data_* inputs.
- CPU has priority; a hold counter bounds M1 starvation.
- Tracks the owner of each read so the one-cycle-late read data returns to the right master.

---
 rtl/data_bus_arbiter_pkg.sv | 19 +
 rtl/data_bus_arbiter_hold_counter.sv | 37 +++
 rtl/data_bus_arbiter.sv | 117 +++++++++++
 tb/tb_data_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared constants for the data-bus arbiter: owner encodings, read marker, hold default.
package data_bus_arbiter_pkg;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam logic [3:0] BYTEEN_READ = 4'b0000;

  localparam int unsigned MAX_HOLD_DEFAULT = 4;
  localparam int unsigned HOLD_W           = 4;

  typedef enum logic [1:0] {
    StIdle = OWNER_IDLE,
    StOwn0 = OWNER_M0,
    StOwn1 = OWNER_M1
  } own_state_e;

endpackage

// File: rtl/data_bus_arbiter_hold_counter.sv
// Saturating starvation counter: counts M0 wins while M1 waits, flags when M1 is owed a slot.
module arb_hold_counter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MaxHold = MAX_HOLD_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [HOLD_W-1:0] MaxCnt = HOLD_W'(MaxHold);

  logic [HOLD_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the bridge data port: CPU-first with bounded M1 starvation,
// and a one-deep read-owner pipeline steering late read data back to the requester.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [3:0]        m0_byteen_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [3:0]        m1_byteen_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [3:0]        s_byteen_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic [1:0]        owner_o
);

  logic       hold_at_max;
  logic       gnt0, gnt1;
  own_state_e state_d, state_q;
  logic       rd_pend_d, rd_pend_q;
  logic       rd_owner_d, rd_owner_q;

  // M1 takes the slot when alone or when M0 has starved it MAX_HOLD times.
  assign gnt1 = m1_req_i & (~m0_req_i | hold_at_max);
  assign gnt0 = m0_req_i & ~gnt1;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  arb_hold_counter #(
    .MaxHold (MAX_HOLD)
  ) u_hold_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (gnt0 & m1_req_i),
    .clr_i    (gnt1 | ~m1_req_i),
    .at_max_o (hold_at_max)
  );

  always_comb begin
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_byteen_o = '0;
    if (gnt0) begin
      s_addr_o   = m0_addr_i;
      s_wdata_o  = m0_wdata_i;
      s_byteen_o = m0_byteen_i;
    end else if (gnt1) begin
      s_addr_o   = m1_addr_i;
      s_wdata_o  = m1_wdata_i;
      s_byteen_o = m1_byteen_i;
    end
  end

  // Owner FSM: state register / next state / output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (gnt0) begin
      state_d = StOwn0;
    end else if (gnt1) begin
      state_d = StOwn1;
    end
  end

  always_comb begin
    owner_o = OWNER_IDLE;
    unique case (state_q)
      StOwn0:  owner_o = OWNER_M0;
      StOwn1:  owner_o = OWNER_M1;
      default: owner_o = OWNER_IDLE;
    endcase
  end

  // Read response pipeline.
  assign rd_pend_d  = (gnt0 | gnt1) & (s_byteen_o == BYTEEN_READ);
  assign rd_owner_d = gnt1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid_o = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid_o = rd_pend_q & rd_owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed literal checks plus randomized traffic vs. a reference model.
module tb_data_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_byteen = '0, m1_byteen = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_byteen;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    owner;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .m0_req_i    (m0_req),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_byteen_i (m0_byteen),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_byteen_i (m1_byteen),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_byteen_o  (s_byteen),
    .s_rdata_i   (s_rdata),
    .owner_o     (owner)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who won last cycle, whether that was a read, and how many
  // times in a row M0 has beaten a waiting M1.
  int m_hold = 0, m_last = 0, m_who = 0;
  bit m_pend = 1'b0;
  int n_hold, n_last, n_who;
  bit n_pend;
  int win;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_byteen;
  bit e_rv0, e_rv1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_hold = 0; m_last = 0; m_pend = 1'b0; m_who = 0;
    end
    if (m0_req && m1_req) win = (m_hold == MH) ? 2 : 1;
    else if (m0_req)      win = 1;
    else if (m1_req)      win = 2;
    else                  win = 0;
    e_addr   = (win == 1) ? m0_addr   : (win == 2) ? m1_addr   : '0;
    e_wdata  = (win == 1) ? m0_wdata  : (win == 2) ? m1_wdata  : '0;
    e_byteen = (win == 1) ? m0_byteen : (win == 2) ? m1_byteen : '0;
    e_rv0 = m_pend && (m_who == 1);
    e_rv1 = m_pend && (m_who == 2);
    check("m0_gnt", m0_gnt, win == 1);
    check("m1_gnt", m1_gnt, win == 2);
    check("s_addr", s_addr, e_addr);
    check("s_wdata", s_wdata, e_wdata);
    check("s_byteen", s_byteen, e_byteen);
    check("owner", owner, m_last);
    check("m0_rvalid", m0_rvalid, e_rv0);
    check("m1_rvalid", m1_rvalid, e_rv1);
    check("m0_rdata", m0_rdata, e_rv0 ? s_rdata : '0);
    check("m1_rdata", m1_rdata, e_rv1 ? s_rdata : '0);
    n_hold = (win == 1 && m1_req) ? ((m_hold + 1 > MH) ? MH : m_hold + 1) : 0;
    n_last = win;
    n_pend = (win != 0) && (e_byteen == 4'b0000);
    n_who  = win;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hold = 0; m_last = 0; m_pend = 1'b0; m_who = 0;
    end else begin
      m_hold = n_hold; m_last = n_last; m_pend = n_pend; m_who = n_who;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_byteen = '0; m1_byteen = '0;
  endtask

  logic [9:0] seq;
  bit p0, p1, g0, g1;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_owner", owner, 2'b00);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    rst_n = 1'b1;

    // No requests: bridge idles, owner idle next cycle.
    @(negedge clk);
    check("idle_s_addr", s_addr, 0);
    check("idle_s_wdata", s_wdata, 0);
    check("idle_s_byteen", s_byteen, 0);
    step();
    @(negedge clk);
    check("idle_owner", owner, 2'b00);

    // Lone M1 read at 0x7F00, data 0x1234 next cycle.
    step();
    m1_req = 1; m1_addr = 32'h0000_7F00; m1_byteen = 4'b0000;
    @(negedge clk);
    check("tc1_gnt", m1_gnt, 1);
    check("tc1_addr", s_addr, 32'h7F00);
    check("tc1_byteen", s_byteen, 0);
    step();
    idle(); s_rdata = 32'h1234;
    @(negedge clk);
    check("tc1_rvalid", m1_rvalid, 1);
    check("tc1_rdata", m1_rdata, 32'h1234);
    check("tc1_m0_rvalid", m0_rvalid, 0);
    check("tc1_owner", owner, 2'b10);

    // M0 write.
    step();
    m0_req = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_byteen = 4'b1111;
    @(negedge clk);
    check("wr_addr", s_addr, 32'h10);
    check("wr_wdata", s_wdata, 32'hDEADBEEF);
    check("wr_byteen", s_byteen, 4'b1111);
    step();
    idle();
    @(negedge clk);
    check("wr_owner", owner, 2'b01);
    check("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);

    // Alternating back-to-back reads.
    step();
    m0_req = 1; m0_addr = 32'h0; s_rdata = 32'h5555;
    step();
    m0_req = 0; m1_req = 1; m1_addr = 32'h4; s_rdata = 32'hA1;
    @(negedge clk);
    check("alt0_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    check("alt0_rdata", m0_rdata, 32'hA1);
    step();
    m1_req = 0; m0_req = 1; m0_addr = 32'h8; s_rdata = 32'hA2;
    @(negedge clk);
    check("alt1_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    check("alt1_rdata", m1_rdata, 32'hA2);
    step();
    idle(); s_rdata = 32'hA3;
    @(negedge clk);
    check("alt2_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    check("alt2_rdata", m0_rdata, 32'hA3);

    // Both hold requests: M1 gets every fifth slot.
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
      @(negedge clk);
      seq[i] = m1_gnt;
    end
    check("hold_seq", seq, 10'b10000_10000);

    // Reset asserted mid-read drops the response.
    step();
    idle(); m0_req = 1; m0_addr = 32'h20;
    step();
    idle();
    #1;
    check("pre_rst_rvalid", m0_rvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check("mid_rst_owner", owner, 2'b00);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);

    // Randomized traffic: each master holds a transaction until granted.
    p0 = 0; p1 = 0; g0 = 0; g1 = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (g0) p0 = 0;
      if (g1) p1 = 0;
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) begin p0 = 0; p1 = 0; end
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; m0_addr = $urandom; m0_wdata = $urandom;
        m0_byteen = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_byteen = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
      end
      m0_req = p0; m1_req = p1;
      s_rdata = $urandom;
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
    end

    step();
    rst_n = 1'b1;
    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
